psum_binarizer: RTL and testbench
=================================

# psum_binarizer

Downstream neighbour of the MAC array. Each lane takes one 6-bit partial sum per pass and adds it to a per-lane accumulator across input-channel passes. On the last pass it compares each accumulator with a per-lane threshold (batch-norm folded) and emits one binary activation bit per lane through a valid/ready handshake. The output feeds the ofmap writeback stage.

## Interface
- MAC_NUM, 256, lane count; must match the MAC array.
- PSUM_W, 6, width of one lane's partial sum.
- ACC_W, 16, accumulator and threshold width.
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- psum_in  in  PSUM_W*MAC_NUM  lane i occupies bits [i*PSUM_W+PSUM_W-1 -: PSUM_W]; unsigned.
- psum_valid  in  1  psum_in holds a valid beat.
- psum_last  in  1  this beat is the final channel pass of the group.
- psum_ready  out  1  the block accepts the beat this cycle.
- thr_wr_en  in  1  threshold write strobe.
- thr_wr_addr  in  $clog2(MAC_NUM)  lane to write.
- thr_wr_data  in  ACC_W  unsigned threshold.
- bin_out  out  MAC_NUM  activation bits; bit i is lane i.
- out_valid  out  1  bin_out is valid.
- out_ready  in  1  downstream accepts bin_out.
- pass_cnt  out  8  passes accepted in the current group (saturates at 255).
- sat_flag  out  1  sticky flag: an accumulator saturated.

## Operation
- A beat is accepted when psum_valid && psum_ready.
- psum_ready = !out_valid || out_ready.
  - Accumulation of the next group overlaps the holding of the previous result.
- FSM has three states.
  - ACCUM: collecting beats. A non-last beat does acc[i] += psum[i] for every lane and increments pass_cnt.
  - EMIT: entered on acceptance of a last beat.
    - In that same cycle, final[i] = acc[i] + psum[i] and bin_out[i] <= (final[i] >= thr[i]).
    - out_valid <= 1, acc <= 0, pass_cnt <= 0.
    - The FSM returns to ACCUM in the same cycle: a one-cycle marker used only for the debug counter.
  - HOLD: out_valid=1 and out_ready=0. bin_out is stable and psum_ready=0.
    - Leaving HOLD requires out_ready.
  - On out_ready while out_valid: out_valid clears next cycle, unless a new last beat is accepted in that cycle. In that case bin_out reloads and out_valid stays 1 (back-to-back).
- Accumulator arithmetic is unsigned ACC_W bits. A sum exceeding 2^ACC_W-1 clamps to all-ones and sets sat_flag.
- sat_flag clears only on rst.
- A single-pass group (first beat has psum_last=1) is legal: final = psum.
- Threshold RAM is a register file of MAC_NUM×ACC_W.
  - A write lands at the clock edge.
  - A compare in the same cycle as a write to that lane uses the old value.
- psum_last is ignored when psum_valid is low.

## Timing
- Reset values: bin_out=0, out_valid=0, pass_cnt=0, sat_flag=0, all acc=0, all thr=0. FSM is in ACCUM.
- psum_ready reads 1 in the first cycle after reset release.
- Latency is 1 cycle from last-beat acceptance to out_valid=1.
- Sustained throughput is one beat per cycle while out_ready is held high.
- When rst is asserted mid-group, partial accumulators, the pending output and the thresholds are discarded.
- pass_cnt counts accepted non-last beats in the current group. It reads 0 after each last beat.

## Configuration
- Macro: PSUM_BINARIZER_RAW_OUT_EN.
- When defined:
  - Adds output acc_out (ACC_W*MAC_NUM), registered alongside bin_out and holding the final sums. Used for debug and non-binarized last layers.
  - acc_out resets to 0 and obeys the same valid/ready handshake.
- When undefined: the port and its registers are absent, and bin_out behaviour is identical.

## Structure
- Shared package (bnn_pkg) holds:
  - PSUM_W and ACC_W defaults.
  - FSM state encoding (ST_ACCUM, ST_EMIT, ST_HOLD).
  - The ACC_MAX constant.
- One natural sub-module, psum_lane: one lane's saturating accumulator and threshold comparator. The top generates MAC_NUM instances plus the shared FSM, handshake and threshold write decode.

## Test plan
- Single pass: thr[0]=10, psum lane0=12 with last=1 → next cycle out_valid=1 and bin_out[0]=1. Lane1 psum=9 with thr=10 → bin_out[1]=0.
- Three passes: lane0 psums 20, 20, 25 (last on third), thr=64 → bin_out[0]=1 (65≥64). With thr=66 → 0. pass_cnt reads 1, then 2, then 0.
- Backpressure: out_ready=0 after emit → psum_ready=0 and bin_out stable for 5 cycles. Raising out_ready accepts a pending last beat in the same cycle and out_valid stays 1 with new data.
- Saturation: ACC_W=8, 11 passes of psum=25 → acc clamps at 255 and sat_flag=1 until rst.
- Threshold race: a write of thr[3]=5 in the same cycle as a last beat with lane3 final=4 and old thr=0 → bin_out[3]=1 (old value). The next group with final=4 → 0.
- Mid-group reset: 2 passes accepted, then rst for 1 cycle → a following single pass psum=3 with thr re-written to 4 gives bin_out=0 (no stale sum), and out_valid=0 during reset.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared widths, FSM encoding and accumulator limit for the psum binarizer slice.
// Pure declarations: no latency, no backpressure.
package bnn_pkg;

    localparam int MAC_NUM_DEF = 256;
    localparam int PSUM_W_DEF  = 6;
    localparam int ACC_W_DEF   = 16;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {ACC_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_EMIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/psum_lane.sv
// One lane: saturating accumulator, threshold register and comparator; result registered on the last beat.
// Latency 1 cycle from last-beat acceptance; stalls are handled by the parent through beat_i.
module psum_lane
    import bnn_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PSUM_W-1:0] psum_i,
    input  logic              beat_i,
    input  logic              last_i,
    input  logic              thr_we_i,
    input  logic [ACC_W-1:0]  thr_wdata_i,
    output logic              bin_o,
    output logic              sat_o
`ifdef PSUM_BINARIZER_RAW_OUT_EN
    ,
    output logic [ACC_W-1:0]  raw_o
`endif
);

    localparam logic [ACC_W-1:0] LANE_MAX = {ACC_W{1'b1}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic             bin_q, bin_d;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_sat;

    assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - PSUM_W){1'b0}}, psum_i};
    assign sum_sat  = sum_wide[ACC_W] ? LANE_MAX : sum_wide[ACC_W-1:0];
    assign sat_o    = beat_i & sum_wide[ACC_W];

    // Compare reads thr_q, so a same-cycle write to this lane only affects the next group.
    always_comb begin
        acc_d = acc_q;
        thr_d = thr_q;
        bin_d = bin_q;
        if (thr_we_i) begin
            thr_d = thr_wdata_i;
        end
        if (beat_i) begin
            if (last_i) begin
                acc_d = '0;
                bin_d = (sum_sat >= thr_q);
            end else begin
                acc_d = sum_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            thr_q <= '0;
            bin_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            thr_q <= thr_d;
            bin_q <= bin_d;
        end
    end

    assign bin_o = bin_q;

`ifdef PSUM_BINARIZER_RAW_OUT_EN
    logic [ACC_W-1:0] raw_q, raw_d;

    always_comb begin
        raw_d = raw_q;
        if (beat_i && last_i) begin
            raw_d = sum_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= '0;
        end else begin
            raw_q <= raw_d;
        end
    end

    assign raw_o = raw_q;
`endif

endmodule

// File: rtl/psum_binarizer.sv
// Accumulates per-lane psums across passes and emits threshold bits; 1-cycle latency, psum_ready = !out_valid || out_ready.
// Optional PSUM_BINARIZER_RAW_OUT_EN adds acc_out carrying the final sums under the same handshake.
module psum_binarizer
    import bnn_pkg::*;
#(
    parameter int MAC_NUM = MAC_NUM_DEF,
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int AW      = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PSUM_W*MAC_NUM-1:0] psum_in,
    input  logic                      psum_valid,
    input  logic                      psum_last,
    output logic                      psum_ready,
    input  logic                      thr_wr_en,
    input  logic [AW-1:0]             thr_wr_addr,
    input  logic [ACC_W-1:0]          thr_wr_data,
    output logic [MAC_NUM-1:0]        bin_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                pass_cnt,
    output logic                      sat_flag
`ifdef PSUM_BINARIZER_RAW_OUT_EN
    ,
    output logic [ACC_W*MAC_NUM-1:0]  acc_out
`endif
);

    state_t             state_q, state_d;
    logic [7:0]         pass_cnt_q, pass_cnt_d;
    logic               sat_q, sat_d;
    logic               beat;
    logic               beat_last;
    logic [MAC_NUM-1:0] lane_sat;
    logic [MAC_NUM-1:0] lane_bin;

    assign beat      = psum_valid && psum_ready;
    assign beat_last = beat && psum_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // A last beat reloads the result register even when a previous result is being drained.
    always_comb begin
        state_d = state_q;
        if (beat_last) begin
            state_d = ST_EMIT;
        end else begin
            case (state_q)
                ST_ACCUM: state_d = ST_ACCUM;
                ST_EMIT,
                ST_HOLD:  state_d = out_ready ? ST_ACCUM : ST_HOLD;
                default:  state_d = ST_ACCUM;
            endcase
        end
    end

    always_comb begin
        out_valid  = 1'b0;
        psum_ready = 1'b1;
        case (state_q)
            ST_EMIT,
            ST_HOLD: begin
                out_valid  = 1'b1;
                psum_ready = out_ready;
            end
            default: begin
                out_valid  = 1'b0;
                psum_ready = 1'b1;
            end
        endcase
    end

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        if (beat) begin
            if (psum_last) begin
                pass_cnt_d = 8'd0;
            end else if (pass_cnt_q != 8'hFF) begin
                pass_cnt_d = pass_cnt_q + 8'd1;
            end
        end
        sat_d = sat_q | (|lane_sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= 8'd0;
            sat_q      <= 1'b0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            sat_q      <= sat_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign sat_flag = sat_q;
    assign bin_out  = lane_bin;

    for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
        logic thr_we;

        assign thr_we = thr_wr_en && (thr_wr_addr == AW'(i));

        psum_lane #(
            .PSUM_W (PSUM_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .psum_i      (psum_in[i*PSUM_W +: PSUM_W]),
            .beat_i      (beat),
            .last_i      (psum_last),
            .thr_we_i    (thr_we),
            .thr_wdata_i (thr_wr_data),
            .bin_o       (lane_bin[i]),
            .sat_o       (lane_sat[i])
`ifdef PSUM_BINARIZER_RAW_OUT_EN
            ,
            .raw_o       (acc_out[i*ACC_W +: ACC_W])
`endif
        );
    end

endmodule

// File: tb/tb_psum_binarizer.sv
// Directed, table-driven bench for psum_binarizer built with an 8-bit accumulator.
module tb_psum_binarizer;

    localparam int MN = 256;
    localparam int PW = 6;
    localparam int AW_ACC = 8;
    localparam int AW = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PW*MN-1:0]   psum_in = '0;
    logic               psum_valid = 1'b0;
    logic               psum_last = 1'b0;
    logic               psum_ready;
    logic               thr_wr_en = 1'b0;
    logic [AW-1:0]      thr_wr_addr = '0;
    logic [AW_ACC-1:0]  thr_wr_data = '0;
    logic [MN-1:0]      bin_out;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [7:0]         pass_cnt;
    logic               sat_flag;
`ifdef PSUM_BINARIZER_RAW_OUT_EN
    logic [AW_ACC*MN-1:0] acc_out;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psum_binarizer #(
        .MAC_NUM (MN),
        .PSUM_W  (PW),
        .ACC_W   (AW_ACC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .psum_in     (psum_in),
        .psum_valid  (psum_valid),
        .psum_last   (psum_last),
        .psum_ready  (psum_ready),
        .thr_wr_en   (thr_wr_en),
        .thr_wr_addr (thr_wr_addr),
        .thr_wr_data (thr_wr_data),
        .bin_out     (bin_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pass_cnt    (pass_cnt),
        .sat_flag    (sat_flag)
`ifdef PSUM_BINARIZER_RAW_OUT_EN
        ,
        .acc_out     (acc_out)
`endif
    );

    typedef struct {
        logic [PW-1:0]     p0;
        logic [PW-1:0]     p1;
        logic [AW_ACC-1:0] t0;
        logic [AW_ACC-1:0] t1;
        logic              e0;
        logic              e1;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [PW*MN-1:0] mk(input logic [PW-1:0] l0, input logic [PW-1:0] l1,
                                            input logic [PW-1:0] l3);
        logic [PW*MN-1:0] v;
        v = '0;
        v[0*PW +: PW] = l0;
        v[1*PW +: PW] = l1;
        v[3*PW +: PW] = l3;
        return v;
    endfunction

    // All tasks start and end at posedge+1.
    task automatic wr_thr(input int lane, input logic [AW_ACC-1:0] val);
        thr_wr_en   = 1'b1;
        thr_wr_addr = AW'(lane);
        thr_wr_data = val;
        @(posedge clk); #1;
        thr_wr_en   = 1'b0;
    endtask

    task automatic send(input logic [PW*MN-1:0] v, input logic last);
        int n;
        n = 0;
        psum_in    = v;
        psum_last  = last;
        psum_valid = 1'b1;
        while (!psum_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!psum_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: psum_ready stayed %0d, expected 1", psum_ready);
        end
        @(posedge clk); #1;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{p0: 6'd12, p1: 6'd9,  t0: 8'd10, t1: 8'd10, e0: 1'b1, e1: 1'b0};
        tbl[1] = '{p0: 6'd10, p1: 6'd10, t0: 8'd10, t1: 8'd11, e0: 1'b1, e1: 1'b0};
        tbl[2] = '{p0: 6'd63, p1: 6'd0,  t0: 8'd64, t1: 8'd0,  e0: 1'b0, e1: 1'b1};
        tbl[3] = '{p0: 6'd0,  p1: 6'd63, t0: 8'd0,  t1: 8'd63, e0: 1'b1, e1: 1'b1};

        do_reset();
        chk("rst_ready", int'(psum_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_bin_any", int'(|bin_out), 0);
        chk("rst_pass_cnt", int'(pass_cnt), 0);
        chk("rst_sat", int'(sat_flag), 0);

        // Threshold write racing a compare on the same lane.
        thr_wr_en   = 1'b1;
        thr_wr_addr = 8'd3;
        thr_wr_data = 8'd5;
        psum_in     = mk(6'd0, 6'd0, 6'd4);
        psum_valid  = 1'b1;
        psum_last   = 1'b1;
        @(posedge clk); #1;
        thr_wr_en  = 1'b0;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        chk("race_valid", int'(out_valid), 1);
        chk("race_bin3_old_thr", int'(bin_out[3]), 1);
        chk("race_bin255", int'(bin_out[255]), 1);
        send(mk(6'd0, 6'd0, 6'd4), 1'b1);
        chk("race_bin3_new_thr", int'(bin_out[3]), 0);

        // Single-pass groups.
        for (int i = 0; i < 4; i++) begin
            wr_thr(0, tbl[i].t0);
            wr_thr(1, tbl[i].t1);
            send(mk(tbl[i].p0, tbl[i].p1, 6'd0), 1'b1);
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("tbl%0d_bin0", i), int'(bin_out[0]), int'(tbl[i].e0));
            chk($sformatf("tbl%0d_bin1", i), int'(bin_out[1]), int'(tbl[i].e1));
            chk($sformatf("tbl%0d_pass_cnt", i), int'(pass_cnt), 0);
        end
        @(posedge clk); #1;
        chk("drain_valid", int'(out_valid), 0);

        // Three-pass accumulation, 20+20+25 = 65.
        wr_thr(0, 8'd64);
        send(mk(6'd20, 6'd0, 6'd0), 1'b0);
        chk("mp_pass_cnt1", int'(pass_cnt), 1);
        chk("mp_valid_mid", int'(out_valid), 0);
        send(mk(6'd20, 6'd0, 6'd0), 1'b0);
        chk("mp_pass_cnt2", int'(pass_cnt), 2);
        send(mk(6'd25, 6'd0, 6'd0), 1'b1);
        chk("mp_pass_cnt0", int'(pass_cnt), 0);
        chk("mp_valid", int'(out_valid), 1);
        chk("mp_bin0_thr64", int'(bin_out[0]), 1);
        wr_thr(0, 8'd66);
        send(mk(6'd20, 6'd0, 6'd0), 1'b0);
        send(mk(6'd20, 6'd0, 6'd0), 1'b0);
        send(mk(6'd25, 6'd0, 6'd0), 1'b1);
        chk("mp_bin0_thr66", int'(bin_out[0]), 0);
        @(posedge clk); #1;

        // Backpressure with a last beat waiting for out_ready.
        wr_thr(0, 8'd10);
        out_ready = 1'b0;
        send(mk(6'd12, 6'd0, 6'd0), 1'b1);
        chk("bp_valid", int'(out_valid), 1);
        psum_in    = mk(6'd5, 6'd0, 6'd0);
        psum_valid = 1'b1;
        psum_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_ready_c%0d", c), int'(psum_ready), 0);
            chk($sformatf("bp_hold_valid_c%0d", c), int'(out_valid), 1);
            chk($sformatf("bp_bin0_c%0d", c), int'(bin_out[0]), 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", int'(psum_ready), 1);
        @(posedge clk); #1;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        chk("bp_b2b_valid", int'(out_valid), 1);
        chk("bp_b2b_bin0", int'(bin_out[0]), 0);
        @(posedge clk); #1;
        chk("bp_drain_valid", int'(out_valid), 0);

        // Saturation: 11 passes of 25 exceed 255.
        wr_thr(0, 8'd255);
        for (int p = 0; p < 10; p++) begin
            send(mk(6'd25, 6'd0, 6'd0), 1'b0);
        end
        chk("sat_pass_cnt10", int'(pass_cnt), 10);
        chk("sat_flag_pre", int'(sat_flag), 0);
        send(mk(6'd25, 6'd0, 6'd0), 1'b1);
        chk("sat_flag_set", int'(sat_flag), 1);
        chk("sat_bin0_clamped", int'(bin_out[0]), 1);
        send(mk(6'd1, 6'd0, 6'd0), 1'b1);
        chk("sat_flag_sticky", int'(sat_flag), 1);
        chk("sat_bin0_after", int'(bin_out[0]), 0);

        // Mid-group reset discards partial sums and the pending result.
        send(mk(6'd50, 6'd0, 6'd0), 1'b0);
        send(mk(6'd50, 6'd0, 6'd0), 1'b0);
        chk("mr_pass_cnt2", int'(pass_cnt), 2);
        out_ready  = 1'b0;
        psum_in    = mk(6'd50, 6'd0, 6'd0);
        psum_valid = 1'b1;
        psum_last  = 1'b1;
        rst        = 1'b1;
        @(posedge clk); #1;
        chk("mr_valid_in_rst", int'(out_valid), 0);
        chk("mr_pass_cnt_rst", int'(pass_cnt), 0);
        chk("mr_sat_cleared", int'(sat_flag), 0);
        rst        = 1'b0;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        out_ready  = 1'b1;
        wr_thr(0, 8'd4);
        send(mk(6'd3, 6'd0, 6'd0), 1'b1);
        chk("mr_valid", int'(out_valid), 1);
        chk("mr_bin0_no_stale", int'(bin_out[0]), 0);
        chk("mr_bin1_thr_cleared", int'(bin_out[1]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
